mult_gen_pipe: RTL and testbench

Fully pipelined 32×32 → 64-bit integer multiplier with a fixed latency of 6 clock cycles and a throughput of one product per cycle. It sits inside the execute-stage multiply functional unit. That unit holds the operands stable in its own registers, waits out the latency with a state counter, and consumes the low 32 bits of the product. The module is the RTL replacement for the vendor `mult_gen_0` core and keeps that core's port names, so existing instantiations are unchanged.

---
 rtl/mult_gen_pkg.sv | 16 +
 rtl/mult_gen_pp16.sv | 21 ++
 rtl/mult_gen_pipe.sv | 89 ++++++++
 tb/tb_mult_gen_pipe.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mult_gen_pkg.sv
// Shared constants and types for the pipelined 32x32 multiplier.
package mult_gen_pkg;
  localparam int MG_A_W     = 32;
  localparam int MG_B_W     = 32;
  localparam int MG_P_W     = 64;
  localparam int MG_LATENCY = 6;
  localparam int MG_HALF_W  = 16;

  typedef logic [MG_A_W-1:0] mg_operand_t;
  typedef logic [MG_P_W-1:0] mg_product_t;

  // Sign-extend a 34-bit partial product to the full product width.
  function automatic mg_product_t mg_sext_pp(input logic [2*MG_HALF_W+1:0] pp);
    return {{(MG_P_W-2*MG_HALF_W-2){pp[2*MG_HALF_W+1]}}, pp};
  endfunction
endpackage

// File: rtl/mult_gen_pp16.sv
// Registered 17x17 signed multiplier; one partial product of the 32x32 tree.
module mult_gen_pp16
  import mult_gen_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MG_HALF_W:0]       a_i,
  input  logic [MG_HALF_W:0]       b_i,
  output logic [2*MG_HALF_W+1:0]   p_o
);
  logic signed [2*MG_HALF_W+1:0] p_d, p_q;

  assign p_d = $signed(a_i) * $signed(b_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign p_o = p_q;
endmodule

// File: rtl/mult_gen_pipe.sv
// 32x32->64 multiplier, 6-stage pipeline, one product per cycle.
// Define MULT_GEN_SIGNED_EN for two's-complement operands; default is unsigned.
module mult_gen_pipe
  import mult_gen_pkg::*;
#(
  parameter int A_W     = 32,
  parameter int B_W     = 32,
  parameter int LATENCY = 6
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic [A_W-1:0] A,
  input  logic [B_W-1:0] B,
  output logic [63:0]    P
);
  localparam int HW  = MG_HALF_W;
  localparam int PPW = 2*HW + 2;

  if (LATENCY != MG_LATENCY || A_W != MG_A_W || B_W != MG_B_W) begin : g_bad_cfg
    $error("mult_gen_pipe: only A_W=32, B_W=32, LATENCY=6 are supported");
  end

  // Stage 1: operand registers
  mg_operand_t a_q, b_q;
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= A;
      b_q <= B;
    end
  end

  logic [HW:0] a_hi, a_lo, b_hi, b_lo;
`ifdef MULT_GEN_SIGNED_EN
  assign a_hi = {a_q[MG_A_W-1], a_q[MG_A_W-1:HW]};
  assign b_hi = {b_q[MG_B_W-1], b_q[MG_B_W-1:HW]};
`else
  assign a_hi = {1'b0, a_q[MG_A_W-1:HW]};
  assign b_hi = {1'b0, b_q[MG_B_W-1:HW]};
`endif
  // Low halves are always magnitudes, regardless of operand signedness.
  assign a_lo = {1'b0, a_q[HW-1:0]};
  assign b_lo = {1'b0, b_q[HW-1:0]};

  // Stage 2: partial products
  logic [PPW-1:0] pp_hh, pp_hl, pp_lh, pp_ll;
  mult_gen_pp16 u_pp_hh (.clk(CLK), .rst(rst), .a_i(a_hi), .b_i(b_hi), .p_o(pp_hh));
  mult_gen_pp16 u_pp_hl (.clk(CLK), .rst(rst), .a_i(a_hi), .b_i(b_lo), .p_o(pp_hl));
  mult_gen_pp16 u_pp_lh (.clk(CLK), .rst(rst), .a_i(a_lo), .b_i(b_hi), .p_o(pp_lh));
  mult_gen_pp16 u_pp_ll (.clk(CLK), .rst(rst), .a_i(a_lo), .b_i(b_lo), .p_o(pp_ll));

  // Stage 3: merge the two cross terms, which share the same 2^16 weight
  logic [PPW:0]   mid_d, mid_q;
  logic [PPW-1:0] hh3_q, ll3_q;
  assign mid_d = {pp_hl[PPW-1], pp_hl} + {pp_lh[PPW-1], pp_lh};

  // Stage 4: fold the cross term into the low product
  mg_product_t    lo_d, lo_q;
  logic [PPW-1:0] hh4_q;
  assign lo_d = mg_sext_pp(ll3_q) + {{(MG_P_W-PPW-1-HW){mid_q[PPW]}}, mid_q, {HW{1'b0}}};

  // Stage 5: add the high product at weight 2^32; stage 6 is the output register
  mg_product_t sum_d, sum_q, p_q;
  assign sum_d = (mg_sext_pp(hh4_q) << (2*HW)) + lo_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      mid_q <= '0;
      hh3_q <= '0;
      ll3_q <= '0;
      lo_q  <= '0;
      hh4_q <= '0;
      sum_q <= '0;
      p_q   <= '0;
    end else begin
      mid_q <= mid_d;
      hh3_q <= pp_hh;
      ll3_q <= pp_ll;
      lo_q  <= lo_d;
      hh4_q <= hh3_q;
      sum_q <= sum_d;
      p_q   <= sum_q;
    end
  end

  assign P = p_q;
endmodule

// File: tb/tb_mult_gen_pipe.sv
// Directed bench for mult_gen_pipe; expectations follow MULT_GEN_SIGNED_EN.
module tb_mult_gen_pipe;
  logic        CLK;
  logic        rst;
  logic [31:0] A, B;
  logic [63:0] P;

  int checks = 0;
  int errors = 0;

  mult_gen_pipe dut (.CLK(CLK), .rst(rst), .A(A), .B(B), .P(P));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic hold_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] exp);
    A = a; B = b;
    for (int i = 0; i < 6; i++) step();
    chk(tag, P, exp);
  endtask

  logic [63:0] exp_ff, exp_mix;

  initial begin
`ifdef MULT_GEN_SIGNED_EN
    exp_ff  = 64'h0000_0000_0000_0001;
    exp_mix = 64'hFFFF_FFFF_FFFF_FFFE;
`else
    exp_ff  = 64'hFFFF_FFFE_0000_0001;
    exp_mix = 64'h0000_0001_FFFF_FFFE;
`endif
    rst = 1'b1; A = 32'd7; B = 32'd9;
    #1;
    chk("reset_t0", P, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", P, 64'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_reset_zero", P, 64'd0);
    end
    step();
    chk("post_reset_first", P, 64'd63);

    // flush, then single-cycle pulse for exact latency
    hold_and_check("flush", 32'd0, 32'd0, 64'd0);
    A = 32'd3; B = 32'd5;
    step();
    A = 32'd0; B = 32'd0;
    for (int i = 0; i < 4; i++) step();
    chk("latency_edge5", P, 64'd0);
    step();
    chk("latency_edge6", P, 64'd15);
    step();
    chk("latency_edge7", P, 64'd0);

    // back-to-back stream
    A = 32'd1;        B = 32'd1;        step();
    A = 32'd2;        B = 32'd3;        step();
    A = 32'h0000FFFF; B = 32'h0000FFFF; step();
    A = 32'h00010000; B = 32'h00010000; step();
    A = 32'd0;        B = 32'd0;        step();
    chk("stream_pre", P, 64'd0);
    step();
    chk("stream_0", P, 64'd1);
    step();
    chk("stream_1", P, 64'd6);
    step();
    chk("stream_2", P, 64'h0000_0000_FFFE_0001);
    step();
    chk("stream_3", P, 64'h0000_0001_0000_0000);
    step();
    chk("stream_end", P, 64'd0);

    hold_and_check("ext_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_ff);
    hold_and_check("ext_8000", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    hold_and_check("mixed", 32'hFFFF_FFFF, 32'd2, exp_mix);
    chk("mixed_lo32", {32'd0, P[31:0]}, 64'h0000_0000_FFFF_FFFE);
    hold_and_check("big_pos", 32'h1234_5678, 32'h0000_1000, 64'h0000_0123_4567_8000);

    // mid-stream reset pulse between edges
    A = 32'd100; B = 32'd3; step();
    A = 32'd200; B = 32'd3; step();
    A = 32'd300; B = 32'd3; step();
    chk("pre_pulse_nonzero", {63'd0, (P != 64'd0)}, 64'd1);
    rst = 1'b1;
    #1;
    chk("async_reset", P, 64'd0);
    #1;
    rst = 1'b0;
    A = 32'd11; B = 32'd13;
    step();
    A = 32'd0; B = 32'd0;
    chk("flushed_1", P, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flushed_n", P, 64'd0);
    end
    step();
    chk("post_pulse_first", P, 64'd143);
    step();
    chk("post_pulse_next", P, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
